// File: rtl/cnn_core_stream_io.sv
// Stream front/back end for cnn_core. It packs an incoming byte stream of
// weights, biases and input fmap into the core's wide buses, fires the core
// once, captures the wide result and streams it back one channel per word.
module cnn_core_stream_io #(
  parameter int CI     = 3,
  parameter int CO     = 16,
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int B_BW   = 8,
  parameter int O_F_BW = 23
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic                          load_wb_i,
  output logic                          busy_o,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [7:0]                    s_data_i,
  output logic [CO*CI*KX*KY*W_BW-1:0]   cnn_weight_o,
  output logic [CO*B_BW-1:0]            cnn_bias_o,
  output logic [CI*KX*KY*I_F_BW-1:0]    in_fmap_o,
  output logic                          core_valid_o,
  input  logic                          core_ot_valid_i,
  input  logic [CO*O_F_BW-1:0]          core_ot_fmap_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [O_F_BW-1:0]             m_data_o,
  output logic [$clog2(CO)-1:0]         m_och_o,
  output logic                          m_last_o
);

  localparam int NW    = CO * CI * KY * KX;  // weight elements
  localparam int NB    = CO;                 // bias elements
  localparam int NF    = CI * KY * KX;       // fmap elements
  localparam int IDX_W = $clog2(NW);         // weights are the longest phase
  localparam int OCH_W = $clog2(CO);

  typedef enum logic [2:0] {IDLE, LD_W, LD_B, LD_F, FIRE, WAIT, SEND} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [OCH_W-1:0]   och_q;
  logic [CO*O_F_BW-1:0] result_q;
  logic               accept;
  logic               capture;
  logic               och_last;

  assign accept   = s_valid_i && s_ready_o;
  assign capture  = ((state_q == FIRE) || (state_q == WAIT)) && core_ot_valid_i;
  assign och_last = (och_q == OCH_W'(CO - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    state_d      = state_q;
    busy_o       = (state_q != IDLE);
    s_ready_o    = 1'b0;
    core_valid_o = 1'b0;
    m_valid_o    = 1'b0;
    m_last_o     = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) state_d = load_wb_i ? LD_W : LD_F;
      LD_W: begin
        s_ready_o = 1'b1;
        if (accept && idx_q == IDX_W'(NW - 1)) state_d = LD_B;
      end
      LD_B: begin
        s_ready_o = 1'b1;
        if (accept && idx_q == IDX_W'(NB - 1)) state_d = LD_F;
      end
      LD_F: begin
        s_ready_o = 1'b1;
        if (accept && idx_q == IDX_W'(NF - 1)) state_d = FIRE;
      end
      FIRE: begin
        core_valid_o = 1'b1;
        state_d      = core_ot_valid_i ? SEND : WAIT;
      end
      WAIT: if (core_ot_valid_i) state_d = SEND;
      SEND: begin
        m_valid_o = 1'b1;
        m_last_o  = och_last;
        if (m_ready_i && och_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Element counter: restarts at 0 on every state change, steps per accepted byte.
  always_ff @(posedge clk) begin
    if (reset)                   idx_q <= '0;
    else if (state_d != state_q) idx_q <= '0;
    else if (accept)             idx_q <= idx_q + IDX_W'(1);
  end

  // Load registers: write the truncated byte into the slot addressed by idx.
  always_ff @(posedge clk) begin
    // NOTE: these wide storage registers are reset on purpose; a reset must
    // wipe stored weights/biases so a stale model can never be reused.
    if (reset) begin
      cnn_weight_o <= '0;
      cnn_bias_o   <= '0;
      in_fmap_o    <= '0;
    end else if (accept) begin
      unique case (state_q)
        LD_W:    cnn_weight_o[int'(idx_q)*W_BW +: W_BW]  <= s_data_i[W_BW-1:0];
        LD_B:    cnn_bias_o[int'(idx_q)*B_BW +: B_BW]    <= s_data_i[B_BW-1:0];
        LD_F:    in_fmap_o[int'(idx_q)*I_F_BW +: I_F_BW] <= s_data_i[I_F_BW-1:0];
        default: ;
      endcase
    end
  end

  // Result register: captured once per job while the core is running.
  always_ff @(posedge clk) begin
    if (reset)        result_q <= '0;
    else if (capture) result_q <= core_ot_fmap_i;
  end

  // Output channel counter: advances per output handshake, wraps after the last.
  always_ff @(posedge clk) begin
    if (reset) och_q <= '0;
    else if (state_q == SEND && m_ready_i) och_q <= och_last ? '0 : och_q + OCH_W'(1);
  end

  assign m_data_o = result_q[int'(och_q)*O_F_BW +: O_F_BW];
  assign m_och_o  = och_q;

endmodule
